// File: rtl/axis_crc32_mpeg2_framer.sv
// rtl/axis_crc32_mpeg2_framer.sv - pairs buffered data words with CRC32/MPEG-2 words into 2-beat AXI-Stream frames
// Optional frame counter output enabled by defining AXIS_CRC32_MPEG2_FRAMER_CNT_EN.
module axis_crc32_mpeg2_framer #(
  parameter int DATA_FIFO_DEPTH = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [31:0]                        s_data_tdata,
  input  logic                               s_data_tvalid,
  output logic                               s_data_tready,
  input  logic [31:0]                        s_crc_tdata,
  input  logic                               s_crc_tvalid,
  output logic                               s_crc_tready,
  output logic [31:0]                        m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [$clog2(DATA_FIFO_DEPTH):0]   fifo_level
`ifdef AXIS_CRC32_MPEG2_FRAMER_CNT_EN
  ,
  output logic [15:0]                        frame_cnt
`endif
);

  localparam int AW = $clog2(DATA_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = DATA_FIFO_DEPTH[LW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem [DATA_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          crc_valid_q, crc_valid_d;
  logic [31:0]   crc_q, crc_d;

  logic push;
  logic pop;
  logic crc_load;
  logic crc_clear;

  // Readies are forced low while reset is held; they depend only on registered state otherwise.
  assign s_data_tready = !areset && (level_q != FULL_LEVEL);
  assign s_crc_tready  = !areset && !crc_valid_q;
  assign push          = s_data_tvalid && s_data_tready;
  assign crc_load      = s_crc_tvalid && s_crc_tready;
  assign fifo_level    = level_q;

  always_comb begin
    state_d       = state_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    pop           = 1'b0;
    crc_clear     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((level_q != '0) && crc_valid_q) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = mem[rd_ptr_q];
        if (m_axis_tready) begin
          pop     = 1'b1;
          state_d = CRC;
        end
      end
      CRC: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = crc_q;
        if (m_axis_tready) begin
          crc_clear = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    crc_valid_d = crc_valid_q;
    crc_d       = crc_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    // Load and clear are mutually exclusive: load needs the register empty, clear needs it full.
    if (crc_clear) begin
      crc_valid_d = 1'b0;
    end else if (crc_load) begin
      crc_valid_d = 1'b1;
      crc_d       = s_crc_tdata;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      crc_valid_q <= 1'b0;
      crc_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      crc_valid_q <= crc_valid_d;
      crc_q       <= crc_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_data_tdata;
    end
  end

`ifdef AXIS_CRC32_MPEG2_FRAMER_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (crc_clear && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_crc32_mpeg2_framer.sv
// tb/tb_axis_crc32_mpeg2_framer.sv - self-checking bench for axis_crc32_mpeg2_framer with a queue-based frame model
module tb_axis_crc32_mpeg2_framer;

  localparam int DEPTH = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_data_tdata;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic [31:0] s_crc_tdata;
  logic        s_crc_tvalid;
  logic        s_crc_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef AXIS_CRC32_MPEG2_FRAMER_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  logic [31:0] q_crc[$];
  int n_data_acc;
  int n_crc_acc;
  int n_frames;
  int frames_since_reset;
  bit out_phase;

  always #5 aclk = ~aclk;

  axis_crc32_mpeg2_framer #(.DATA_FIFO_DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_data_tdata  (s_data_tdata),
    .s_data_tvalid (s_data_tvalid),
    .s_data_tready (s_data_tready),
    .s_crc_tdata   (s_crc_tdata),
    .s_crc_tvalid  (s_crc_tvalid),
    .s_crc_tready  (s_crc_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_level    (fifo_level)
`ifdef AXIS_CRC32_MPEG2_FRAMER_CNT_EN
    ,
    .frame_cnt     (frame_cnt)
`endif
  );

  task automatic clear_model();
    q_data.delete();
    q_crc.delete();
    n_data_acc = 0;
    n_crc_acc = 0;
    out_phase = 1'b0;
    frames_since_reset = 0;
  endtask

  // One clock cycle: sample handshakes at the falling edge into the frame model, then advance to just after the rising edge.
  task automatic step();
    @(negedge aclk);
    if (!areset) begin
      if (s_data_tvalid && s_data_tready) begin
        q_data.push_back(s_data_tdata);
        n_data_acc++;
      end
      if (s_crc_tvalid && s_crc_tready) begin
        q_crc.push_back(s_crc_tdata);
        n_crc_acc++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (!out_phase) begin
          if (q_data.size() == 0) begin
            errors++;
            $display("FAIL sb_data_beat: got unexpected beat %h, required no beat", m_axis_tdata);
          end else begin
            if (m_axis_tdata !== q_data[0] || m_axis_tlast !== 1'b0) begin
              errors++;
              $display("FAIL sb_data_beat: got %h/tlast=%0b, required %h/tlast=0", m_axis_tdata, m_axis_tlast, q_data[0]);
            end
            q_data.delete(0);
          end
          out_phase = 1'b1;
        end else begin
          if (q_crc.size() == 0) begin
            errors++;
            $display("FAIL sb_crc_beat: got unexpected beat %h, required no beat", m_axis_tdata);
          end else begin
            if (m_axis_tdata !== q_crc[0] || m_axis_tlast !== 1'b1) begin
              errors++;
              $display("FAIL sb_crc_beat: got %h/tlast=%0b, required %h/tlast=1", m_axis_tdata, m_axis_tlast, q_crc[0]);
            end
            q_crc.delete(0);
          end
          out_phase = 1'b0;
          n_frames++;
          frames_since_reset++;
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  // Supplies CRC words for every outstanding data word until the framer is empty.
  task automatic drain(input int max_cycles);
    int c;
    int bd;
    int bc;
    m_axis_tready = 1'b1;
    for (c = 0; c < max_cycles; c++) begin
      if (!s_data_tvalid && n_crc_acc == n_data_acc && q_data.size() == 0 && q_crc.size() == 0 && !m_axis_tvalid) break;
      s_crc_tvalid = (n_crc_acc < n_data_acc + (s_data_tvalid ? 1 : 0));
      bd = n_data_acc;
      bc = n_crc_acc;
      step();
      if (n_data_acc != bd) s_data_tvalid = 1'b0;
      if (n_crc_acc != bc) s_crc_tdata = $urandom;
    end
    s_crc_tvalid = 1'b0;
    checks++;
    if (c >= max_cycles) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending beats after %0d cycles, required 0", q_data.size() + q_crc.size(), max_cycles);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_data_tvalid = 1'b0;
    s_crc_tvalid = 1'b0;
    s_data_tdata = '0;
    s_crc_tdata = '0;
    m_axis_tready = 1'b0;
    n_frames = 0;
    clear_model();
    step();
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b l=%0b d=%h, required 0/0/0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    checks++;
    if (s_data_tready !== 1'b0 || s_crc_tready !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_ready: got dr=%0b cr=%0b lvl=%0d, required 0/0/0", s_data_tready, s_crc_tready, fifo_level);
    end
    areset = 1'b0;
    step();
    checks++;
    if (s_data_tready !== 1'b1 || s_crc_tready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got dr=%0b cr=%0b, required 1/1", s_data_tready, s_crc_tready);
    end
`ifdef AXIS_CRC32_MPEG2_FRAMER_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
    end
`endif
  endtask

  task automatic test_basic_frame();
    m_axis_tready = 1'b1;
    s_data_tdata = 32'h12345678;
    s_data_tvalid = 1'b1;
    s_crc_tdata = 32'hA1B2C3D4;
    s_crc_tvalid = 1'b1;
    step();
    s_data_tvalid = 1'b0;
    s_crc_tvalid = 1'b0;
    checks++;
    if (fifo_level !== 3'd1 || m_axis_tvalid !== 1'b0 || s_crc_tready !== 1'b0) begin
      errors++;
      $display("FAIL basic_loaded: got lvl=%0d v=%0b cr=%0b, required 1/0/0", fifo_level, m_axis_tvalid, s_crc_tready);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h12345678 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL basic_data: got v=%0b d=%h l=%0b, required 1/12345678/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA1B2C3D4 || m_axis_tlast !== 1'b1 || s_crc_tready !== 1'b0) begin
      errors++;
      $display("FAIL basic_crc: got v=%0b d=%h l=%0b cr=%0b, required 1/a1b2c3d4/1/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_crc_tready);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_crc_tready !== 1'b1 || fifo_level !== '0) begin
      errors++;
      $display("FAIL basic_idle: got v=%0b cr=%0b lvl=%0d, required 0/1/0", m_axis_tvalid, s_crc_tready, fifo_level);
    end
  endtask

  task automatic test_crc_first();
    m_axis_tready = 1'b1;
    s_crc_tdata = 32'hDEADBEEF;
    s_crc_tvalid = 1'b1;
    step();
    s_crc_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_crc_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL crc_held: cycle %0d got cr=%0b v=%0b, required 0/0", i, s_crc_tready, m_axis_tvalid);
      end
      step();
    end
    s_data_tdata = 32'h00000001;
    s_data_tvalid = 1'b1;
    step();
    s_data_tvalid = 1'b0;
    step();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00000001 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL crc_first_data: got v=%0b d=%h l=%0b, required 1/00000001/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    step();
    checks++;
    if (m_axis_tdata !== 32'hDEADBEEF || m_axis_tlast !== 1'b1) begin
      errors++;
      $display("FAIL crc_first_crc: got d=%h l=%0b, required deadbeef/1", m_axis_tdata, m_axis_tlast);
    end
    step();
  endtask

  task automatic test_fifo_full();
    m_axis_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s_data_tdata = $urandom;
      s_data_tvalid = 1'b1;
      step();
    end
    s_data_tdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fifo_level !== 3'd4 || s_data_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL fifo_full: cycle %0d got lvl=%0d dr=%0b v=%0b, required 4/0/0", i, fifo_level, s_data_tready, m_axis_tvalid);
      end
      step();
    end
    drain(200);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [31:0] c;
    d = $urandom;
    c = $urandom;
    m_axis_tready = 1'b0;
    s_data_tdata = d;
    s_data_tvalid = 1'b1;
    s_crc_tdata = c;
    s_crc_tvalid = 1'b1;
    step();
    s_data_tvalid = 1'b0;
    s_crc_tvalid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_tlast !== 1'b0 || fifo_level !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%0b d=%h l=%0b lvl=%0d, required 1/%h/0/1", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_level, d);
      end
      step();
    end
    m_axis_tready = 1'b1;
    step();
    checks++;
    if (m_axis_tdata !== c || m_axis_tlast !== 1'b1 || fifo_level !== '0) begin
      errors++;
      $display("FAIL bp_release: got d=%h l=%0b lvl=%0d, required %h/1/0", m_axis_tdata, m_axis_tlast, fifo_level, c);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    m_axis_tready = 1'b0;
    s_data_tdata = $urandom;
    s_data_tvalid = 1'b1;
    s_crc_tdata = $urandom;
    s_crc_tvalid = 1'b1;
    step();
    s_crc_tvalid = 1'b0;
    s_data_tdata = $urandom;
    step();
    s_data_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    checks++;
    if (m_axis_tlast !== 1'b1 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL mid_in_crc: got l=%0b lvl=%0d, required 1/1", m_axis_tlast, fifo_level);
    end
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL mid_async: got v=%0b l=%0b d=%h lvl=%0d, required 0/0/0/0", m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_level);
    end
    checks++;
    if (s_data_tready !== 1'b0 || s_crc_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready: got dr=%0b cr=%0b, required 0/0", s_data_tready, s_crc_tready);
    end
    clear_model();
    step();
    areset = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (m_axis_tvalid !== 1'b0 || fifo_level !== '0) begin
        errors++;
        $display("FAIL mid_discard: cycle %0d got v=%0b lvl=%0d, required 0/0", i, m_axis_tvalid, fifo_level);
      end
    end
  endtask

  task automatic test_random_frames();
    int sent_d;
    int sent_c;
    int start_frames;
    int cyc;
    int bd;
    int bc;
    sent_d = 0;
    sent_c = 0;
    start_frames = n_frames;
    for (cyc = 0; cyc < 3000 && (sent_d < 10 || sent_c < 10); cyc++) begin
      if (!s_data_tvalid && sent_d < 10 && $urandom_range(0, 1) == 1) begin
        s_data_tdata = $urandom;
        s_data_tvalid = 1'b1;
      end
      if (!s_crc_tvalid && sent_c < 10 && $urandom_range(0, 1) == 1) begin
        s_crc_tdata = $urandom;
        s_crc_tvalid = 1'b1;
      end
      m_axis_tready = ($urandom_range(0, 1) == 1);
      bd = n_data_acc;
      bc = n_crc_acc;
      step();
      if (n_data_acc != bd) begin
        s_data_tvalid = 1'b0;
        sent_d++;
      end
      if (n_crc_acc != bc) begin
        s_crc_tvalid = 1'b0;
        sent_c++;
      end
    end
    checks++;
    if (sent_d != 10 || sent_c != 10) begin
      errors++;
      $display("FAIL random_accept: got data=%0d crc=%0d accepted, required 10/10", sent_d, sent_c);
    end
    drain(200);
    checks++;
    if (n_frames - start_frames != 10) begin
      errors++;
      $display("FAIL random_frames: got %0d frames, required 10", n_frames - start_frames);
    end
`ifdef AXIS_CRC32_MPEG2_FRAMER_CNT_EN
    checks++;
    if (frame_cnt !== frames_since_reset[15:0]) begin
      errors++;
      $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, frames_since_reset);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_crc_first();
    test_fifo_full();
    test_backpressure();
    test_reset_mid_frame();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
